// File: rtl/i2c_tgt_pkg.sv
// Shared types and constants for the I2C laser-driver register target.
// The state encoding is exported on STATE for status readback and ChipScope.
`timescale 1ns/1ps
package i2c_tgt_pkg;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_DEV       = 4'd1,
    ST_DEV_ACK   = 4'd2,
    ST_REG       = 4'd3,
    ST_REG_ACK   = 4'd4,
    ST_WR        = 4'd5,
    ST_WR_ACK    = 4'd6,
    ST_RD        = 4'd7,
    ST_RD_ACK    = 4'd8,
    ST_WAIT_STOP = 4'd9
  } tgt_state_e;

  // Bit-counter value that marks the ninth (acknowledge) clock of a byte.
  localparam logic [3:0] ACK_BIT = 4'd8;

  function automatic int REG_IDX_W(input int n_regs);
    return (n_regs <= 2) ? 1 : $clog2(n_regs);
  endfunction

endpackage

// File: rtl/i2c_bus_sync.sv
// Brings SCL/SDA into the CLK40 domain and produces one-cycle edge, START and
// STOP pulses, three CLK40 cycles after the pad change.
`timescale 1ns/1ps
module i2c_bus_sync (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_scl,
  input  logic i_sda,
  output logic o_scl_rise,
  output logic o_scl_fall,
  output logic o_start,
  output logic o_stop,
  output logic o_sda
);

  logic [1:0] r_scl_sync;
  logic [1:0] r_sda_sync;
  logic       r_scl_hist;
  logic       r_sda_hist;
  logic       r_scl_rise;
  logic       r_scl_fall;
  logic       r_start;
  logic       r_stop;

  // Flops reset to the idle-bus level so leaving reset never fakes an event.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_scl_sync <= 2'b11;
      r_sda_sync <= 2'b11;
      r_scl_hist <= 1'b1;
      r_sda_hist <= 1'b1;
      r_scl_rise <= 1'b0;
      r_scl_fall <= 1'b0;
      r_start    <= 1'b0;
      r_stop     <= 1'b0;
    end else begin
      r_scl_sync <= {r_scl_sync[0], i_scl};
      r_sda_sync <= {r_sda_sync[0], i_sda};
      r_scl_hist <= r_scl_sync[1];
      r_sda_hist <= r_sda_sync[1];
      r_scl_rise <= r_scl_sync[1] & ~r_scl_hist;
      r_scl_fall <= ~r_scl_sync[1] & r_scl_hist;
      r_start    <= r_scl_sync[1] & r_scl_hist & r_sda_hist & ~r_sda_sync[1];
      r_stop     <= r_scl_sync[1] & r_scl_hist & ~r_sda_hist & r_sda_sync[1];
    end
  end

  assign o_scl_rise = r_scl_rise;
  assign o_scl_fall = r_scl_fall;
  assign o_start    = r_start;
  assign o_stop     = r_stop;
  // Data bit aligned with the registered pulses.
  assign o_sda      = r_sda_hist;

endmodule

// File: rtl/i2c_ld_target.sv
// I2C target emulating the laser-driver register file for loopback and
// bring-up builds: pointer writes, burst writes and burst reads.
`timescale 1ns/1ps
module i2c_ld_target
  import i2c_tgt_pkg::*;
#(
  parameter logic [7:0]  DEV_ADDR     = 8'hFC,
  parameter int          N_REGS       = 7,
  parameter logic [55:0] REG_DEFAULTS = 56'h04FFFF88008087
) (
  input  logic                  CLK40,
  input  logic                  rst_fifo,
  input  logic                  SCL_IN,
  input  logic                  SDA_IN,
  output logic                  SDA_OE,
  output logic [8*N_REGS-1:0]   REGS,
  output logic                  WR_STB,
  output logic [3:0]            WR_IDX,
  output logic                  BUSY,
  output logic [3:0]            STATE
);

  localparam int             PW       = REG_IDX_W(N_REGS);
  localparam logic [PW-1:0]  LAST_IDX = PW'(N_REGS - 1);

  logic w_scl_rise;
  logic w_scl_fall;
  logic w_start;
  logic w_stop;
  logic w_sda;

  tgt_state_e    r_state;
  tgt_state_e    w_state_nxt;
  logic [3:0]    r_bitcnt;
  logic [3:0]    w_bitcnt_nxt;
  logic [7:0]    r_shift;
  logic [7:0]    w_shift_nxt;
  logic [PW-1:0] r_ptr;
  logic [PW-1:0] w_ptr_nxt;
  logic [PW-1:0] w_ptr_inc;
  logic          r_sda_oe;
  logic          w_sda_oe_nxt;
  logic          r_busy;
  logic          w_busy_nxt;
  logic          w_wr_en;
  logic          r_wr_stb;
  logic [3:0]    r_wr_idx;
  logic [7:0]    r_regs [N_REGS];
  logic [7:0]    w_byte_in;
  logic [7:0]    w_rd_cur;
  logic [7:0]    w_rd_inc;
  logic          w_addr_match;
  logic          w_reg_ok;

  i2c_bus_sync u_sync (
    .i_clk      (CLK40),
    .i_rst      (rst_fifo),
    .i_scl      (SCL_IN),
    .i_sda      (SDA_IN),
    .o_scl_rise (w_scl_rise),
    .o_scl_fall (w_scl_fall),
    .o_start    (w_start),
    .o_stop     (w_stop),
    .o_sda      (w_sda)
  );

  assign w_ptr_inc    = (r_ptr == LAST_IDX) ? '0 : r_ptr + PW'(1);
  assign w_byte_in    = {r_shift[6:0], w_sda};
  assign w_rd_cur     = r_regs[r_ptr];
  assign w_rd_inc     = r_regs[w_ptr_inc];
  assign w_addr_match = (r_shift[7:1] == DEV_ADDR[7:1]);
  assign w_reg_ok     = (r_shift < 8'(N_REGS));

  always_ff @(posedge CLK40 or posedge rst_fifo) begin
    if (rst_fifo) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_bitcnt_nxt = r_bitcnt;
    w_shift_nxt  = r_shift;
    w_ptr_nxt    = r_ptr;
    w_sda_oe_nxt = r_sda_oe;
    w_busy_nxt   = r_busy;
    w_wr_en      = 1'b0;
    if (w_stop) begin
      w_state_nxt  = ST_IDLE;
      w_bitcnt_nxt = '0;
      w_sda_oe_nxt = 1'b0;
      w_busy_nxt   = 1'b0;
    end else if (w_start) begin
      // Pointer survives a repeated START so write-pointer + Sr + read works.
      w_state_nxt  = ST_DEV;
      w_bitcnt_nxt = '0;
      w_sda_oe_nxt = 1'b0;
    end else begin
      unique case (r_state)
        ST_DEV, ST_REG, ST_WR: begin
          if (w_scl_rise && r_bitcnt != ACK_BIT) begin
            w_shift_nxt  = w_byte_in;
            w_bitcnt_nxt = r_bitcnt + 4'd1;
            if (r_state == ST_WR && r_bitcnt == ACK_BIT - 4'd1) w_wr_en = 1'b1;
          end else if (w_scl_fall && r_bitcnt == ACK_BIT) begin
            if (r_state == ST_DEV) begin
              if (w_addr_match) begin
                w_state_nxt  = ST_DEV_ACK;
                w_sda_oe_nxt = 1'b1;
                w_busy_nxt   = 1'b1;
              end else begin
                w_state_nxt  = ST_WAIT_STOP;
                w_busy_nxt   = 1'b0;
              end
            end else if (r_state == ST_REG) begin
              if (w_reg_ok) begin
                w_state_nxt  = ST_REG_ACK;
                w_ptr_nxt    = r_shift[PW-1:0];
                w_sda_oe_nxt = 1'b1;
              end else begin
                w_state_nxt  = ST_WAIT_STOP;
                w_busy_nxt   = 1'b0;
              end
            end else begin
              w_state_nxt  = ST_WR_ACK;
              w_sda_oe_nxt = 1'b1;
            end
          end
        end
        ST_DEV_ACK: begin
          // Read: load on the ACK clock rise so the first bit goes out on its fall.
          if (w_scl_rise && r_shift[0]) begin
            w_state_nxt  = ST_RD;
            w_shift_nxt  = w_rd_cur;
            w_bitcnt_nxt = '0;
          end else if (w_scl_fall && !r_shift[0]) begin
            w_state_nxt  = ST_REG;
            w_sda_oe_nxt = 1'b0;
            w_bitcnt_nxt = '0;
          end
        end
        ST_REG_ACK, ST_WR_ACK: begin
          if (w_scl_fall) begin
            w_state_nxt  = ST_WR;
            w_sda_oe_nxt = 1'b0;
            w_bitcnt_nxt = '0;
            if (r_state == ST_WR_ACK) w_ptr_nxt = w_ptr_inc;
          end
        end
        ST_RD: begin
          if (w_scl_rise && r_bitcnt != ACK_BIT) begin
            w_shift_nxt  = {r_shift[6:0], 1'b0};
            w_bitcnt_nxt = r_bitcnt + 4'd1;
          end else if (w_scl_fall) begin
            if (r_bitcnt == ACK_BIT) begin
              w_state_nxt  = ST_RD_ACK;
              w_sda_oe_nxt = 1'b0;
            end else begin
              w_sda_oe_nxt = ~r_shift[7];
            end
          end
        end
        ST_RD_ACK: begin
          if (w_scl_rise) begin
            if (!w_sda) begin
              w_state_nxt  = ST_RD;
              w_ptr_nxt    = w_ptr_inc;
              w_shift_nxt  = w_rd_inc;
              w_bitcnt_nxt = '0;
            end else begin
              w_state_nxt  = ST_WAIT_STOP;
              w_busy_nxt   = 1'b0;
            end
          end
        end
        ST_WAIT_STOP: begin
          w_sda_oe_nxt = 1'b0;
          w_busy_nxt   = 1'b0;
        end
        default: begin
          w_sda_oe_nxt = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK40 or posedge rst_fifo) begin
    if (rst_fifo) begin
      r_bitcnt <= '0;
      r_shift  <= '0;
      r_ptr    <= '0;
      r_sda_oe <= 1'b0;
      r_busy   <= 1'b0;
      r_wr_stb <= 1'b0;
      r_wr_idx <= '0;
      for (int i = 0; i < N_REGS; i++) r_regs[i] <= REG_DEFAULTS[8*i +: 8];
    end else begin
      r_bitcnt <= w_bitcnt_nxt;
      r_shift  <= w_shift_nxt;
      r_ptr    <= w_ptr_nxt;
      r_sda_oe <= w_sda_oe_nxt;
      r_busy   <= w_busy_nxt;
      r_wr_stb <= w_wr_en;
      if (w_wr_en) begin
        r_regs[r_ptr] <= w_byte_in;
        r_wr_idx      <= 4'(r_ptr);
      end
    end
  end

  genvar g;
  generate
    for (g = 0; g < N_REGS; g++) begin : g_regs_out
      assign REGS[8*g +: 8] = r_regs[g];
    end
  endgenerate

  assign SDA_OE = r_sda_oe;
  assign WR_STB = r_wr_stb;
  assign WR_IDX = r_wr_idx;
  assign BUSY   = r_busy;
  assign STATE  = r_state;

endmodule

// File: tb/tb_i2c_ld_target.sv
// Directed bench for i2c_ld_target: a bit-banged I2C master on an open-drain
// SDA line, a table of pointer/read vectors and hand-written corner sequences.
`timescale 1ns/1ps
module tb_i2c_ld_target;
  import i2c_tgt_pkg::*;

  localparam int          Q        = 200;
  localparam logic [55:0] DEFAULTS = 56'h04FFFF88008087;

  logic        CLK40 = 1'b0;
  logic        rst_fifo;
  logic        m_scl;
  logic        m_sda;
  logic        sda_bus;
  logic        SDA_OE;
  logic [55:0] REGS;
  logic        WR_STB;
  logic [3:0]  WR_IDX;
  logic        BUSY;
  logic [3:0]  STATE;

  assign sda_bus = m_sda & ~SDA_OE;

  always #12.5 CLK40 = ~CLK40;

  i2c_ld_target #(
    .DEV_ADDR     (8'hFC),
    .N_REGS       (7),
    .REG_DEFAULTS (DEFAULTS)
  ) dut (
    .CLK40    (CLK40),
    .rst_fifo (rst_fifo),
    .SCL_IN   (m_scl),
    .SDA_IN   (sda_bus),
    .SDA_OE   (SDA_OE),
    .REGS     (REGS),
    .WR_STB   (WR_STB),
    .WR_IDX   (WR_IDX),
    .BUSY     (BUSY),
    .STATE    (STATE)
  );

  int   checks   = 0;
  int   failures = 0;
  int   wr_log[$];
  logic oe_seen   = 1'b0;
  logic wait_seen = 1'b0;

  always @(negedge CLK40) begin
    if (WR_STB === 1'b1) wr_log.push_back(int'(WR_IDX));
    if (SDA_OE === 1'b1) oe_seen = 1'b1;
    if (STATE == 4'(ST_WAIT_STOP)) wait_seen = 1'b1;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic bus_start();
    m_sda = 1'b1; m_scl = 1'b1; #Q;
    m_sda = 1'b0; #Q;
    m_scl = 1'b0; #Q;
  endtask

  task automatic bus_rstart();
    m_sda = 1'b1; #Q;
    m_scl = 1'b1; #Q;
    m_sda = 1'b0; #Q;
    m_scl = 1'b0; #Q;
  endtask

  task automatic bus_stop();
    m_sda = 1'b0; #Q;
    m_scl = 1'b1; #Q;
    m_sda = 1'b1; #(2*Q);
  endtask

  task automatic clk_bit(input logic b, output logic s);
    m_sda = b; #Q;
    m_scl = 1'b1; #Q;
    s = sda_bus; #Q;
    m_scl = 1'b0; #Q;
  endtask

  task automatic wr_byte(input logic [7:0] d, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) clk_bit(d[i], s);
    clk_bit(1'b1, s);
    ack = ~s;
  endtask

  task automatic rd_byte(input logic nack, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      clk_bit(1'b1, s);
      d[i] = s;
    end
    clk_bit(nack, s);
  endtask

  typedef struct {
    logic [7:0] ptr;
    logic       exp_ack;
    logic [7:0] exp_data;
  } vec_t;

  vec_t       vecs[7];
  logic [7:0] burst[7];
  logic [8:0] acks;
  logic       a;
  logic [7:0] d;

  initial begin
    burst = '{8'h64, 8'h55, 8'h33, 8'hE7, 8'h1C, 8'h73, 8'h02};
    // Pointer vectors run after the burst write; a NACKed pointer leaves the previous one.
    vecs[0] = '{8'h03, 1'b1, 8'hE7};
    vecs[1] = '{8'h06, 1'b1, 8'h02};
    vecs[2] = '{8'h00, 1'b1, 8'h64};
    vecs[3] = '{8'h07, 1'b0, 8'h64};
    vecs[4] = '{8'h20, 1'b0, 8'h64};
    vecs[5] = '{8'h05, 1'b1, 8'h73};
    vecs[6] = '{8'hFF, 1'b0, 8'h73};

    rst_fifo = 1'b1; m_scl = 1'b1; m_sda = 1'b1;
    #(4*Q);
    check("rst_sda_oe", SDA_OE, 1'b0);
    check("rst_regs",   REGS, DEFAULTS);
    check("rst_wr_stb", WR_STB, 1'b0);
    check("rst_wr_idx", WR_IDX, 4'd0);
    check("rst_busy",   BUSY, 1'b0);
    check("rst_state",  STATE, ST_IDLE);
    rst_fifo = 1'b0;
    #(2*Q);

    // Burst write of all seven registers.
    wr_log.delete();
    bus_start();
    wr_byte(8'hFC, acks[8]);
    wr_byte(8'h00, acks[7]);
    for (int i = 0; i < 7; i++) wr_byte(burst[i], acks[6-i]);
    check("burst_acks", acks, 9'h1FF);
    check("burst_busy", BUSY, 1'b1);
    bus_stop();
    check("burst_regs", REGS, 56'h02731CE7335564);
    check("burst_stb_count", wr_log.size(), 7);
    for (int i = 0; i < 7 && i < wr_log.size(); i++) check($sformatf("burst_idx%0d", i), wr_log[i], i);
    check("burst_busy_after", BUSY, 1'b0);
    check("burst_state_after", STATE, ST_IDLE);

    // Combined pointer write, repeated START, burst read.
    wr_log.delete();
    bus_start();
    wr_byte(8'hFC, acks[2]);
    wr_byte(8'h00, acks[1]);
    bus_rstart();
    wr_byte(8'hFD, acks[0]);
    check("comb_acks", acks[2:0], 3'b111);
    check("comb_busy", BUSY, 1'b1);
    for (int i = 0; i < 7; i++) begin
      rd_byte(i == 6, d);
      check($sformatf("comb_rd%0d", i), d, burst[i]);
    end
    check("comb_busy_nack", BUSY, 1'b0);
    check("comb_state_nack", STATE, ST_WAIT_STOP);
    bus_stop();
    check("comb_state_stop", STATE, ST_IDLE);
    check("comb_no_write", wr_log.size(), 0);

    for (int v = 0; v < 7; v++) begin
      bus_start();
      wr_byte(8'hFC, a);
      check($sformatf("vec%0d_dev_ack", v), a, 1'b1);
      wr_byte(vecs[v].ptr, a);
      check($sformatf("vec%0d_reg_ack", v), a, vecs[v].exp_ack);
      check($sformatf("vec%0d_state", v), STATE, vecs[v].exp_ack ? ST_WR : ST_WAIT_STOP);
      bus_rstart();
      wr_byte(8'hFD, a);
      rd_byte(1'b1, d);
      check($sformatf("vec%0d_data", v), d, vecs[v].exp_data);
      bus_stop();
    end

    // Foreign address: never acknowledged, remaining bytes ignored.
    oe_seen = 1'b0; wait_seen = 1'b0;
    bus_start();
    wr_byte(8'hA0, a);
    check("wrong_addr_ack", a, 1'b0);
    check("wrong_addr_state", STATE, ST_WAIT_STOP);
    wr_byte(8'h11, a);
    bus_stop();
    check("wrong_addr_oe", oe_seen, 1'b0);
    check("wrong_addr_wait", wait_seen, 1'b1);
    check("wrong_addr_regs", REGS, 56'h02731CE7335564);
    check("wrong_addr_idle", STATE, ST_IDLE);

    // Burst crossing the last register wraps to register 0.
    wr_log.delete();
    bus_start();
    wr_byte(8'hFC, acks[4]);
    wr_byte(8'h05, acks[3]);
    wr_byte(8'hAA, acks[2]);
    wr_byte(8'hBB, acks[1]);
    wr_byte(8'hCC, acks[0]);
    bus_stop();
    check("wrap_acks", acks[4:0], 5'h1F);
    check("wrap_regs", REGS, 56'hBBAA1CE73355CC);
    check("wrap_stb_count", wr_log.size(), 3);
    if (wr_log.size() == 3) begin
      check("wrap_idx0", wr_log[0], 5);
      check("wrap_idx1", wr_log[1], 6);
      check("wrap_idx2", wr_log[2], 0);
    end

    // Pointer-only transfer, then a fresh read from that pointer.
    wr_log.delete();
    bus_start();
    wr_byte(8'hFC, a);
    wr_byte(8'h02, a);
    bus_stop();
    check("ptr_only_no_write", wr_log.size(), 0);
    bus_start();
    wr_byte(8'hFD, a);
    rd_byte(1'b1, d);
    bus_stop();
    check("ptr_only_read", d, 8'h33);

    // STOP after half a data byte discards it.
    bus_start();
    wr_byte(8'hFC, a);
    wr_byte(8'h03, a);
    clk_bit(1'b1, a); clk_bit(1'b0, a); clk_bit(1'b1, a); clk_bit(1'b0, a);
    bus_stop();
    check("partial_no_write", wr_log.size(), 0);
    check("partial_regs", REGS, 56'hBBAA1CE73355CC);
    check("partial_idle", STATE, ST_IDLE);

    // Reset while the target is pulling SDA low during a read (reg2 = 33, MSB 0).
    bus_start();
    wr_byte(8'hFC, a);
    wr_byte(8'h02, a);
    bus_rstart();
    wr_byte(8'hFD, a);
    check("rstrd_oe_driven", SDA_OE, 1'b1);
    check("rstrd_state", STATE, ST_RD);
    rst_fifo = 1'b1;
    #1;
    check("rstrd_oe_async", SDA_OE, 1'b0);
    #(Q-1);
    check("rstrd_regs", REGS, DEFAULTS);
    check("rstrd_idle", STATE, ST_IDLE);
    check("rstrd_busy", BUSY, 1'b0);
    rst_fifo = 1'b0;
    #Q;
    wr_log.delete();
    bus_stop();
    check("rstrd_stop_state", STATE, ST_IDLE);
    check("rstrd_stop_regs", REGS, DEFAULTS);
    check("rstrd_stop_oe", SDA_OE, 1'b0);
    check("rstrd_stop_nowrite", wr_log.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
